tx_cpl_engine: RTL

//  Transmit-side counterpart of the RX OCP bridge. Pops 2-beat memory-read request headers from the Tx header AXI

---
 rtl/tx_cpl_engine.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/tx_cpl_engine.sv
// tx_cpl_engine: turns 2-beat memory-read request headers plus OCP read-response
// words into 3DW CplD TLPs on a 64-bit PCIe TX stream. Payload DWs are shifted
// behind the odd third header DW through a 32-bit hold register.
//
// state | meaning
// IDLE  | waiting for header beat0 (also the beat0 acceptance state)
// HDR1  | beat0 latched, waiting for header beat1
// CPL0  | sending {DW1,DW0} of the completion header
// CPL1  | sending {payload DW0, DW2}; needs the first OCP word
// DATA  | sending payload pairs {sdata lo, hold}, or a final {0, hold}
module tx_cpl_engine #(
    parameter int axi_width  = 64,
    parameter int keep_width = 8
) (
    input  logic                  tx_clk,
    input  logic                  tx_reset,
    input  logic [15:0]           completer_id,
    input  logic                  tx_header_fifo_valid,
    input  logic [axi_width-1:0]  tx_header_fifo_data,
    input  logic [keep_width-1:0] tx_header_fifo_keep,
    input  logic                  tx_header_fifo_last,
    output logic                  tx_header_fifo_ready,
    input  logic [1:0]            sresp,
    input  logic [axi_width-1:0]  sdata,
    output logic                  mresp_accept,
    output logic                  tx_valid,
    output logic [axi_width-1:0]  tx_data,
    output logic [keep_width-1:0] tx_keep,
    output logic                  tx_last,
    input  logic                  tx_ready,
    output logic                  cpl_busy,
    output logic                  cpl_error
);

    localparam logic [1:0] SRESP_NULL = 2'b00;
    localparam logic [1:0] SRESP_ERR  = 2'b11;

    typedef enum logic [2:0] {IDLE, HDR1, CPL0, CPL1, DATA} state_t;

    state_t      state_q, state_d;
    logic [9:0]  len_q;
    logic [2:0]  tc_q;
    logic [1:0]  attr_q;
    logic [15:0] req_id_q;
    logic [7:0]  tag_q;
    logic [4:0]  lower_q;
    logic [31:0] hold_q, hold_d;
    logic [10:0] rem_q, rem_d;
    logic        hdr0_load, hdr1_load;

    logic [11:0] byte_count;
    logic [31:0] cpl_dw0, cpl_dw1, cpl_dw2;
    logic        unused_inputs;

    // Byte count wraps to 0 for a 1024-DW read, which the 10-bit length already encodes.
    assign byte_count = {len_q, 2'b00};
    assign cpl_dw0    = {3'b010, 5'b01010, 1'b0, tc_q, 4'b0000, 2'b00, attr_q, 2'b00, len_q};
    assign cpl_dw1    = {completer_id, 3'b000, 1'b0, byte_count};
    assign cpl_dw2    = {req_id_q, tag_q, 1'b0, lower_q, 2'b00};
    assign cpl_busy   = (state_q != IDLE);

    // Header bits outside the captured fields and the byte enables carry nothing we use.
    assign unused_inputs = ^{tx_header_fifo_keep, tx_header_fifo_data};

    // State, latched header fields, hold register and DW countdown.
    always_ff @(posedge tx_clk or posedge tx_reset) begin
        if (tx_reset) begin
            state_q  <= IDLE;
            len_q    <= '0;
            tc_q     <= '0;
            attr_q   <= '0;
            req_id_q <= '0;
            tag_q    <= '0;
            lower_q  <= '0;
            hold_q   <= '0;
            rem_q    <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            rem_q   <= rem_d;
            if (hdr0_load) begin
                len_q    <= tx_header_fifo_data[9:0];
                tc_q     <= tx_header_fifo_data[22:20];
                attr_q   <= tx_header_fifo_data[13:12];
                req_id_q <= tx_header_fifo_data[63:48];
                tag_q    <= tx_header_fifo_data[47:40];
            end
            if (hdr1_load) begin
                lower_q <= tx_header_fifo_data[6:2];
            end
        end
    end

    // Next state and stream outputs; outputs are gated off while reset is held.
    always_comb begin
        state_d              = state_q;
        hold_d               = hold_q;
        rem_d                = rem_q;
        hdr0_load            = 1'b0;
        hdr1_load            = 1'b0;
        tx_header_fifo_ready = 1'b0;
        tx_valid             = 1'b0;
        tx_data              = '0;
        tx_keep              = '0;
        tx_last              = 1'b0;
        mresp_accept         = 1'b0;
        cpl_error            = 1'b0;
        case (state_q)
            IDLE: begin
                tx_header_fifo_ready = !tx_reset;
                if (tx_header_fifo_valid && !tx_reset) begin
                    if (tx_header_fifo_last) begin
                        cpl_error = 1'b1;
                    end else begin
                        hdr0_load = 1'b1;
                        state_d   = HDR1;
                    end
                end
            end
            HDR1: begin
                tx_header_fifo_ready = !tx_reset;
                if (tx_header_fifo_valid && !tx_reset) begin
                    if (tx_header_fifo_last) begin
                        hdr1_load = 1'b1;
                        rem_d     = (len_q == 10'd0) ? 11'd1024 : {1'b0, len_q};
                        state_d   = CPL0;
                    end else begin
                        cpl_error = 1'b1;
                        state_d   = IDLE;
                    end
                end
            end
            CPL0: begin
                tx_valid = 1'b1;
                tx_data  = {cpl_dw1, cpl_dw0};
                tx_keep  = 8'hFF;
                if (tx_ready) begin
                    state_d = CPL1;
                end
            end
            CPL1: begin
                tx_valid = (sresp != SRESP_NULL);
                tx_data  = {sdata[31:0], cpl_dw2};
                tx_keep  = 8'hFF;
                tx_last  = (rem_q == 11'd1);
                if (tx_valid && tx_ready) begin
                    mresp_accept = 1'b1;
                    cpl_error    = (sresp == SRESP_ERR);
                    hold_d       = sdata[63:32];
                    rem_d        = rem_q - 11'd1;
                    state_d      = tx_last ? IDLE : DATA;
                end
            end
            DATA: begin
                if (rem_q >= 11'd2) begin
                    tx_valid = (sresp != SRESP_NULL);
                    tx_data  = {sdata[31:0], hold_q};
                    tx_keep  = 8'hFF;
                    tx_last  = (rem_q == 11'd2);
                    if (tx_valid && tx_ready) begin
                        mresp_accept = 1'b1;
                        cpl_error    = (sresp == SRESP_ERR);
                        hold_d       = sdata[63:32];
                        rem_d        = rem_q - 11'd2;
                        state_d      = tx_last ? IDLE : DATA;
                    end
                end else begin
                    // Odd tail: the last DW already sits in hold, no OCP word needed.
                    tx_valid = 1'b1;
                    tx_data  = {32'h0, hold_q};
                    tx_keep  = 8'h0F;
                    tx_last  = 1'b1;
                    if (tx_ready) begin
                        rem_d   = '0;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule
